screen_seq_fsm: RTL

SCREEN_SEQ_FSM -- requirements
Module: screen_seq_fsm

---
 rtl/screen_seq_fsm_pkg.sv | 28 ++
 rtl/screen_seq_fsm_if.sv | 23 ++
 rtl/screen_seq_fsm_sec_tick_gen.sv | 28 ++
 rtl/screen_seq_fsm.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/screen_seq_fsm_pkg.sv
// Shared screen-sequencer types: the screen enumeration and a dwell-time lookup.
package common_enums;

    // PAUSE_SCREEN is always enumerated; without SCREEN_PAUSE_EN it is an illegal encoding.
    typedef enum logic [2:0] {
        TITLE_SCREEN  = 3'd0,
        PLAYER_SCREEN = 3'd1,
        SETUP_SCREEN  = 3'd2,
        CHESS_SCREEN  = 3'd3,
        RESULT_SCREEN = 3'd4,
        PAUSE_SCREEN  = 3'd5
    } screen_state_t;

    localparam int unsigned SECS_W = 8;

    function automatic logic [SECS_W-1:0] dwell_secs(
        input screen_state_t     s,
        input logic [SECS_W-1:0] player_sec,
        input logic [SECS_W-1:0] result_sec
    );
        case (s)
            PLAYER_SCREEN: return player_sec;
            RESULT_SCREEN: return result_sec;
            default:       return '0;
        endcase
    endfunction

endpackage

// File: rtl/screen_seq_fsm_if.sv
// Bundle of the screen sequencer's button/event inputs and screen status outputs.
interface screen_seq_fsm_if;
    import common_enums::*;

    logic          enter;
    logic          back;
    logic          game_over;
    logic          pause;
    screen_state_t state;
    logic          state_entry;
    logic [7:0]    secs_left;

    modport master (
        output enter, back, game_over, pause,
        input  state, state_entry, secs_left
    );

    modport slave (
        input  enter, back, game_over, pause,
        output state, state_entry, secs_left
    );

endinterface

// File: rtl/screen_seq_fsm_sec_tick_gen.sv
// One-cycle tick every CLK_FREQ_HZ cycles, phase restarted by clear.
module sec_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(CLK_FREQ_HZ);
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/screen_seq_fsm.sv
// Game screen sequencer: title/player/setup/chess/result flow with timed dwells.
// Optional PAUSE_SCREEN support is built when SCREEN_PAUSE_EN is defined.
module screen_seq_fsm
    import common_enums::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned PLAYER_SEC  = 2,
    parameter int unsigned RESULT_SEC  = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enter,
    input  logic          back,
    input  logic          game_over,
    input  logic          pause,
    output screen_state_t state,
    output logic          state_entry,
    output logic [7:0]    secs_left
);

    localparam logic [SECS_W-1:0] P_SEC = SECS_W'(PLAYER_SEC);
    localparam logic [SECS_W-1:0] R_SEC = SECS_W'(RESULT_SEC);

    screen_state_t     r_state;
    screen_state_t     w_next;
    logic              r_entry;
    logic [SECS_W-1:0] r_elapsed;
    logic [SECS_W-1:0] w_dwell;
    logic              w_clear;
    logic              w_tick;
    logic              w_timeout;

    // r_armed masks the first cycle after reset so an already-high input is not an edge.
    logic r_armed;
    logic r_enter_q;
    logic r_back_q;
    logic w_enter_edge;
    logic w_back_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed   <= 1'b0;
            r_enter_q <= 1'b0;
            r_back_q  <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_enter_q <= enter;
            r_back_q  <= back;
        end
    end

    assign w_enter_edge = enter & ~r_enter_q & r_armed;
    assign w_back_edge  = back  & ~r_back_q  & r_armed;

`ifdef SCREEN_PAUSE_EN
    logic r_pause_q;
    logic w_pause_edge;
    logic r_go_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pause_q <= 1'b0;
            r_go_pend <= 1'b0;
        end else begin
            r_pause_q <= pause;
            // A game_over seen while paused is replayed once play resumes.
            if (w_next == TITLE_SCREEN || r_state == CHESS_SCREEN) begin
                r_go_pend <= 1'b0;
            end else if (r_state == PAUSE_SCREEN && game_over) begin
                r_go_pend <= 1'b1;
            end
        end
    end

    assign w_pause_edge = pause & ~r_pause_q & r_armed;
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
`endif

    sec_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_sec_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (w_clear),
        .tick   (w_tick)
    );

    assign w_dwell   = dwell_secs(r_state, P_SEC, R_SEC);
    assign w_timeout = w_tick && (w_dwell != '0) && (r_elapsed == w_dwell - 1'b1);
    assign w_clear   = (w_next != r_state);

    always_comb begin
        w_next = r_state;
        case (r_state)
            TITLE_SCREEN: begin
                if (w_enter_edge) w_next = PLAYER_SCREEN;
            end
            PLAYER_SCREEN: begin
                if (w_timeout) w_next = SETUP_SCREEN;
            end
            SETUP_SCREEN: begin
                if (w_back_edge)       w_next = TITLE_SCREEN;
                else if (w_enter_edge) w_next = CHESS_SCREEN;
            end
            CHESS_SCREEN: begin
`ifdef SCREEN_PAUSE_EN
                if (game_over || r_go_pend) w_next = RESULT_SCREEN;
                else if (w_pause_edge)      w_next = PAUSE_SCREEN;
`else
                if (game_over) w_next = RESULT_SCREEN;
`endif
            end
            RESULT_SCREEN: begin
                if (w_timeout || w_enter_edge) w_next = TITLE_SCREEN;
            end
`ifdef SCREEN_PAUSE_EN
            PAUSE_SCREEN: begin
                if (w_back_edge)                       w_next = TITLE_SCREEN;
                else if (w_pause_edge || w_enter_edge) w_next = CHESS_SCREEN;
            end
`endif
            default: w_next = TITLE_SCREEN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= TITLE_SCREEN;
            r_entry   <= 1'b0;
            r_elapsed <= '0;
        end else begin
            r_state <= w_next;
            r_entry <= w_clear;
            if (w_clear) begin
                r_elapsed <= '0;
            end else if (w_tick && r_elapsed != '1) begin
                r_elapsed <= r_elapsed + 1'b1;
            end
        end
    end

    assign state       = r_state;
    assign state_entry = r_entry;
    assign secs_left   = (w_dwell > r_elapsed) ? (w_dwell - r_elapsed) : '0;

endmodule
